weight_bias_streamer: RTL and testbench



---
 rtl/weight_bias_streamer.sv | 141 ++++++++++++++
 tb/tb_weight_bias_streamer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bias_streamer.sv
// rtl/weight_bias_streamer.sv - weight/bias beat streamer for the PE array; WBS_BIAS_EN enables bias fetch
module weight_bias_streamer #(
  parameter int WORD_BITS = 16,
  parameter int ADDR_BITS = 10,
  parameter int TAP_BITS  = 8,
  parameter int OUT_BITS  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start_in,
  input  logic                 En_in,
  input  logic                 layer_done_in,
  input  logic [TAP_BITS-1:0]  taps_in,
  input  logic [OUT_BITS-1:0]  outputs_in,
  input  logic [ADDR_BITS-1:0] weight_base_in,
  input  logic [ADDR_BITS-1:0] bias_base_in,
  output logic                 WRAM_en_out,
  output logic [ADDR_BITS-1:0] WRAM_addr_out,
  input  logic [WORD_BITS-1:0] WRAM_dout_in,
  output logic                 BRAM_en_out,
  output logic [ADDR_BITS-1:0] BRAM_addr_out,
  input  logic [WORD_BITS-1:0] BRAM_dout_in,
  output logic                 Weight_valid_out,
  output logic [WORD_BITS-1:0] Weight_out,
  output logic                 Bias_valid_out,
  output logic [WORD_BITS-1:0] Bias_out,
  output logic                 busy_out,
  output logic                 done_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [TAP_BITS-1:0]  r_taps;
  logic [TAP_BITS-1:0]  r_t;
  logic [OUT_BITS-1:0]  r_outs;
  logic [OUT_BITS-1:0]  r_o;
  logic [ADDR_BITS-1:0] r_waddr;
  logic                 r_w_iss;
  logic                 w_start;
  logic                 w_issue;
  logic                 w_last_tap;
  logic                 w_last_out;

  assign w_start    = (r_state == S_IDLE) && start_in && En_in;
  assign w_issue    = (r_state == S_RUN) && En_in;
  assign w_last_tap = (r_t == r_taps - TAP_BITS'(1));
  assign w_last_out = (r_o == r_outs - OUT_BITS'(1));

  // State register; abort and reset both land in IDLE
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; every advance waits for En_in, abort overrides all
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = (taps_in == '0 || outputs_in == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_issue && w_last_tap && w_last_out) w_next = S_DRAIN;
      S_DRAIN: if (En_in) w_next = S_DONE;
      S_DONE:  if (En_in) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (layer_done_in) w_next = S_IDLE;
  end

  // Config latch, tap/output counters and running weight address
  always_ff @(posedge CLK) begin
    if (RST || layer_done_in) begin
      r_taps  <= '0;
      r_outs  <= '0;
      r_t     <= '0;
      r_o     <= '0;
      r_waddr <= '0;
    end else if (w_start) begin
      r_taps  <= taps_in;
      r_outs  <= outputs_in;
      r_t     <= '0;
      r_o     <= '0;
      r_waddr <= weight_base_in;
    end else if (w_issue) begin
      r_waddr <= r_waddr + ADDR_BITS'(1);
      if (w_last_tap) begin
        r_t <= '0;
        r_o <= r_o + OUT_BITS'(1);
      end else begin
        r_t <= r_t + TAP_BITS'(1);
      end
    end
  end

  // Weight-issued flag; frozen while En_in is low so a stalled beat is re-presented
  always_ff @(posedge CLK) begin
    if (RST || layer_done_in) r_w_iss <= 1'b0;
    else if (En_in)           r_w_iss <= (r_state == S_RUN);
  end

  assign WRAM_en_out      = w_issue;
  assign WRAM_addr_out    = r_waddr;
  assign Weight_valid_out = r_w_iss && En_in;
  assign Weight_out       = Weight_valid_out ? WRAM_dout_in : '0;
  assign busy_out         = (r_state != S_IDLE);
  assign done_out         = (r_state == S_DONE) && En_in;

`ifdef WBS_BIAS_EN
  logic [ADDR_BITS-1:0] r_bias_base;
  logic                 r_b_iss;
  logic                 w_bias_issue;

  assign w_bias_issue = w_issue && (r_t == '0);

  // Bias base latch; bias address is derived from it and the output counter
  always_ff @(posedge CLK) begin
    if (RST || layer_done_in) r_bias_base <= '0;
    else if (w_start)         r_bias_base <= bias_base_in;
  end

  // Bias-issued flag, tracking the tap-0 weight read of each output
  always_ff @(posedge CLK) begin
    if (RST || layer_done_in) r_b_iss <= 1'b0;
    else if (En_in)           r_b_iss <= w_bias_issue;
  end

  assign BRAM_en_out    = w_bias_issue;
  assign BRAM_addr_out  = r_bias_base + ADDR_BITS'(r_o);
  assign Bias_valid_out = r_b_iss && En_in;
  assign Bias_out       = Bias_valid_out ? BRAM_dout_in : '0;
`else
  logic w_unused_bias;

  assign w_unused_bias  = ^{bias_base_in, BRAM_dout_in};
  assign BRAM_en_out    = 1'b0;
  assign BRAM_addr_out  = '0;
  assign Bias_valid_out = 1'b0;
  assign Bias_out       = '0;
`endif

endmodule

// File: tb/tb_weight_bias_streamer.sv
// tb/tb_weight_bias_streamer.sv - scoreboard bench for weight_bias_streamer
module tb_weight_bias_streamer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start_in;
  logic        En_in;
  logic        layer_done_in;
  logic [7:0]  taps_in;
  logic [7:0]  outputs_in;
  logic [9:0]  weight_base_in;
  logic [9:0]  bias_base_in;
  logic        WRAM_en_out;
  logic [9:0]  WRAM_addr_out;
  logic [15:0] WRAM_dout_in;
  logic        BRAM_en_out;
  logic [9:0]  BRAM_addr_out;
  logic [15:0] BRAM_dout_in;
  logic        Weight_valid_out;
  logic [15:0] Weight_out;
  logic        Bias_valid_out;
  logic [15:0] Bias_out;
  logic        busy_out;
  logic        done_out;

  typedef struct {
    logic [15:0] w;
    logic [15:0] b;
    logic        hb;
  } beat_t;

  beat_t      sb[$];
  logic [9:0] addr_log[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         first_beat = -1;
  int         last_beat = -1;
  int         done_cnt = 0;

  weight_bias_streamer dut (
    .CLK(CLK), .RST(RST), .start_in(start_in), .En_in(En_in),
    .layer_done_in(layer_done_in), .taps_in(taps_in), .outputs_in(outputs_in),
    .weight_base_in(weight_base_in), .bias_base_in(bias_base_in),
    .WRAM_en_out(WRAM_en_out), .WRAM_addr_out(WRAM_addr_out), .WRAM_dout_in(WRAM_dout_in),
    .BRAM_en_out(BRAM_en_out), .BRAM_addr_out(BRAM_addr_out), .BRAM_dout_in(BRAM_dout_in),
    .Weight_valid_out(Weight_valid_out), .Weight_out(Weight_out),
    .Bias_valid_out(Bias_valid_out), .Bias_out(Bias_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 CLK = ~CLK;

  // RAM models: data equals address, one-cycle latency, hold when not enabled
  initial begin
    WRAM_dout_in = '0;
    BRAM_dout_in = '0;
  end
  always @(posedge CLK) begin
    if (WRAM_en_out) WRAM_dout_in <= {6'b0, WRAM_addr_out};
    if (BRAM_en_out) BRAM_dout_in <= {6'b0, BRAM_addr_out};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every weight beat
  always @(negedge CLK) begin
    beat_t e;
    logic  exp_bv;
    if (done_out) done_cnt++;
    if (WRAM_en_out) addr_log.push_back(WRAM_addr_out);
    if (!En_in)
      check_eq("stall_quiet", {27'b0, Weight_valid_out, Bias_valid_out, WRAM_en_out, BRAM_en_out, done_out}, 32'd0);
    if (Weight_valid_out) begin
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
`ifdef WBS_BIAS_EN
        exp_bv = e.hb;
`else
        exp_bv = 1'b0;
`endif
        check_eq("weight", Weight_out, e.w);
        check_eq("bias_valid", Bias_valid_out, exp_bv);
        check_eq("bias", Bias_out, exp_bv ? e.b : 16'h0);
      end
    end else begin
      check_eq("bias_orphan", Bias_valid_out, 1'b0);
    end
  end

  // One layer from start at cycle 0; returns at the negedge after done (or after kill_cyc)
  task automatic run_layer(input int taps, input int outs, input int wbase, input int bbase,
                           input int stall_lo, input int stall_hi, input int kill_cyc,
                           input bit kill_rst, input int extra_start, output int done_cyc);
    logic [9:0] wa;
    for (int o = 0; o < outs; o++)
      for (int t = 0; t < taps; t++) begin
        beat_t e;
        wa   = 10'(wbase + o * taps + t);
        e.w  = {6'b0, wa};
        e.b  = {6'b0, 10'(bbase + o)};
        e.hb = (t == 0);
        sb.push_back(e);
      end
    @(posedge CLK); #1;
    cyc = 0;
    first_beat = -1;
    last_beat = -1;
    addr_log.delete();
    done_cyc = -1;
    taps_in = 8'(taps);
    outputs_in = 8'(outs);
    weight_base_in = 10'(wbase);
    bias_base_in = 10'(bbase);
    start_in = 1'b1;
    En_in = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (done_out && done_cyc < 0) done_cyc = cyc;
      if (kill_cyc >= 0 && cyc == kill_cyc + 1) break;
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
      @(posedge CLK); #1;
      cyc++;
      start_in = (cyc == extra_start);
      if (cyc == extra_start) begin
        taps_in = 8'd1;
        outputs_in = 8'd1;
      end
      En_in = !(cyc >= stall_lo && cyc <= stall_hi);
      layer_done_in = !kill_rst && (cyc == kill_cyc);
      RST = kill_rst && (cyc == kill_cyc);
    end
    if (kill_cyc < 0 && done_cyc < 0) check_eq("done_timeout", 32'(cyc), 32'd0);
  endtask

  int d;
  int dc;

  initial begin
    RST = 1'b1;
    start_in = 1'b0;
    En_in = 1'b1;
    layer_done_in = 1'b0;
    taps_in = '0;
    outputs_in = '0;
    weight_base_in = '0;
    bias_base_in = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_valids", {Weight_valid_out, Bias_valid_out, WRAM_en_out, BRAM_en_out}, 4'd0);
    check_eq("rst_status", {busy_out, done_out}, 2'd0);
    check_eq("rst_data", {Weight_out, Bias_out}, 32'd0);
    check_eq("rst_addr", {WRAM_addr_out, BRAM_addr_out}, 20'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // basic run
    dc = done_cnt;
    run_layer(3, 2, 'h010, 'h004, 1000, 1000, -1, 0, -1, d);
    check_eq("basic_done", d, 8);
    check_eq("basic_first", first_beat, 2);
    check_eq("basic_last", last_beat, 7);
    check_eq("basic_busy", busy_out, 1'b0);
    check_eq("basic_drained", sb.size(), 0);
    check_eq("basic_done_cnt", done_cnt - dc, 1);

    // stall cycles 3-4
    run_layer(3, 2, 'h010, 'h004, 3, 4, -1, 0, -1, d);
    check_eq("stall_done", d, 10);
    check_eq("stall_last", last_beat, 9);
    check_eq("stall_drained", sb.size(), 0);

    // stall in DONE suppresses done_out
    run_layer(3, 2, 'h010, 'h004, 8, 8, -1, 0, -1, d);
    check_eq("stall_done_state", d, 9);

    // abort at cycle 4
    dc = done_cnt;
    run_layer(3, 2, 'h010, 'h004, 1000, 1000, 4, 0, -1, d);
    check_eq("abort_outs", {busy_out, Weight_valid_out, Bias_valid_out, WRAM_en_out, BRAM_en_out, done_out}, 6'd0);
    check_eq("abort_no_done", done_cnt - dc, 0);
    check_eq("abort_left", sb.size(), 3);
    sb.delete();

    // clean restart right after abort
    run_layer(3, 2, 'h010, 'h004, 1000, 1000, -1, 0, -1, d);
    check_eq("restart_done", d, 8);
    check_eq("restart_drained", sb.size(), 0);

    // degenerate configs
    run_layer(0, 5, 'h020, 'h008, 1000, 1000, -1, 0, -1, d);
    check_eq("degen_done", d, 1);
    check_eq("degen_no_beats", first_beat, -1);
    check_eq("degen_busy", busy_out, 1'b0);
    run_layer(2, 0, 'h020, 'h008, 1000, 1000, -1, 0, -1, d);
    check_eq("degen2_done", d, 1);

    // address wrap
    run_layer(4, 1, 'h3FE, 'h3FF, 1000, 1000, -1, 0, -1, d);
    check_eq("wrap_done", d, 6);
    check_eq("wrap_n", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check_eq("wrap_a0", addr_log[0], 10'h3FE);
      check_eq("wrap_a1", addr_log[1], 10'h3FF);
      check_eq("wrap_a2", addr_log[2], 10'h000);
      check_eq("wrap_a3", addr_log[3], 10'h001);
    end

    // start while busy is ignored
    run_layer(3, 2, 'h010, 'h004, 1000, 1000, -1, 0, 3, d);
    check_eq("ign_start_done", d, 8);
    check_eq("ign_start_drained", sb.size(), 0);

    // reset mid-run
    run_layer(3, 2, 'h010, 'h004, 1000, 1000, 4, 1, -1, d);
    check_eq("midrst_outs", {busy_out, Weight_valid_out, Bias_valid_out, WRAM_en_out, BRAM_en_out, done_out}, 6'd0);
    check_eq("midrst_data", {Weight_out, Bias_out}, 32'd0);
    check_eq("midrst_addr", {WRAM_addr_out, BRAM_addr_out}, 20'd0);
    check_eq("midrst_left", sb.size(), 3);
    sb.delete();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
